// File: rtl/rcv_filt_seq_if.sv
// rcv_filt_seq_if: sample handshake and coefficient-write bus for rcv_filt_seq.
//   x_in/x_valid/x_ready    : input sample handshake (1s17 samples)
//   y/y_valid               : filter result and its one-cycle strobe (2s16)
//   coef_we/addr/data/err   : coefficient bank write port and reject pulse
// master = upstream/test side, slave = filter.
interface rcv_filt_seq_if;
    logic [17:0] x_in;
    logic        x_valid;
    logic        x_ready;
    logic [17:0] y;
    logic        y_valid;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [17:0] coef_data;
    logic        coef_err;

    modport master (
        output x_in, x_valid, coef_we, coef_addr, coef_data,
        input  x_ready, y, y_valid, coef_err
    );

    modport slave (
        input  x_in, x_valid, coef_we, coef_addr, coef_data,
        output x_ready, y, y_valid, coef_err
    );
endinterface

// File: rtl/rcv_filt_seq.sv
// rcv_filt_seq: 21-tap symmetric receive filter computed with one shared 18x18
// multiplier over 11 MAC cycles per accepted sample.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : rcv_filt_seq_if.slave (sample handshake, result, coefficient writes)
// Throughput is one sample per 13 clocks: accept, 11 MAC steps, 1 result cycle.
module rcv_filt_seq (
    input logic         clk,
    input logic         reset,
    rcv_filt_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    localparam logic signed [17:0] CoefDefault [11] = '{
        18'sd2817, 18'sd4060, 18'sd2289, -18'sd2373, -18'sd7348, -18'sd8574,
        -18'sd2772, 18'sd10263, 18'sd26830, 18'sd40696, 18'sd46096
    };

    state_e state_q, state_d;

    logic signed [17:0] d_q [21];
    logic signed [17:0] b_q [11];
    logic signed [17:0] acc_q;
    logic signed [17:0] y_q;
    logic [3:0]         k_q;
    logic               y_valid_q;
    logic               coef_err_q;

    logic               accept;
    logic               coef_ok;
    logic [4:0]         idx_lo;
    logic [4:0]         idx_hi;
    logic signed [17:0] pair;
    logic signed [35:0] product;
    logic signed [17:0] acc_d;

    always_comb begin
        accept  = (state_q == StIdle) && bus.x_valid;
        coef_ok = (state_q == StIdle) && bus.coef_we && (bus.coef_addr <= 4'd10);
        idx_lo  = {1'b0, k_q};
        idx_hi  = 5'd20 - idx_lo;
        // Fold symmetric taps; the center tap has no partner.
        pair    = (k_q == 4'd10) ? d_q[10] : d_q[idx_lo] + d_q[idx_hi];
        product = 36'(pair) * 36'(b_q[k_q]);
        // Keep product bits [34:17]; accumulator wraps without saturation.
        acc_d   = acc_q + 18'(product >>> 17);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (k_q == 4'd10) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 21; i++) d_q[i] <= '0;
            for (int i = 0; i < 11; i++) b_q[i] <= CoefDefault[i];
            acc_q      <= '0;
            k_q        <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            y_valid_q  <= 1'b0;
            coef_err_q <= bus.coef_we && !coef_ok;
            // A write on the accept edge lands before the first MAC step uses it.
            if (coef_ok) b_q[bus.coef_addr] <= bus.coef_data;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        d_q[0] <= $signed(bus.x_in) >>> 1;
                        for (int i = 1; i < 21; i++) d_q[i] <= d_q[i-1];
                        acc_q <= '0;
                        k_q   <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 4'd1;
                end
                StDone: begin
                    y_q       <= acc_q;
                    y_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.x_ready  = (state_q == StIdle);
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.coef_err = coef_err_q;

endmodule
